// File: rtl/perceptron_trainer.sv
// Sequential perceptron trainer: one shared multiply-accumulate, saturating weight/bias updates.
// Optional EPOCH_LIMIT_EN adds max_epochs / limit_hit to stop training after a number of error epochs.
`timescale 1ns/1ps
module perceptron_trainer #(
  parameter int N_IN = 2,
  parameter int DW   = 8,
  parameter int WW   = 16
) (
  input  logic                 clk,
`ifdef EPOCH_LIMIT_EN
  input  logic [15:0]          max_epochs,
  output logic                 limit_hit,
`endif
  input  logic                 rst,
  input  logic                 start,
  output logic                 sample_req,
  input  logic                 sample_valid,
  input  logic [N_IN*DW-1:0]   sample_x,
  input  logic                 sample_t,
  input  logic                 sample_last,
  output logic                 done,
  output logic                 busy,
  output logic                 converged,
  output logic [15:0]          epoch_cnt,
  output logic [N_IN*WW-1:0]   w_out,
  output logic [WW-1:0]        b_out
);

  localparam int CW = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int AW = WW + DW + $clog2(N_IN) + 1;
  localparam int PW = WW + DW;
  localparam int SW = ((WW > DW) ? WW : DW) + 2;
  localparam logic [CW-1:0] LAST_IDX = CW'(N_IN - 1);
  localparam logic signed [SW-1:0] S_MAX = {{(SW-WW+1){1'b0}}, {(WW-1){1'b1}}};
  localparam logic signed [SW-1:0] S_MIN = {{(SW-WW+1){1'b1}}, {(WW-1){1'b0}}};
  localparam logic signed [SW-1:0] S_ONE = SW'(1);

  typedef enum logic [2:0] {IDLE, INIT, REQ, MAC, DECIDE, UPDATE, EPOCH_END} state_t;

  state_t                 state_q, state_d;
  logic [N_IN*WW-1:0]     w_q, w_d;
  logic signed [WW-1:0]   b_q, b_d;
  logic signed [AW-1:0]   acc_q, acc_d;
  logic [CW-1:0]          idx_q, idx_d;
  logic [N_IN*DW-1:0]     x_q, x_d;
  logic                   t_q, t_d;
  logic                   last_q, last_d;
  logic                   err_q, err_d;
  logic                   conv_q, conv_d;
  logic [15:0]            ecnt_q, ecnt_d;
`ifdef EPOCH_LIMIT_EN
  logic                   lim_q, lim_d;
`endif

  logic signed [WW-1:0]   w_sel;
  logic signed [DW-1:0]   x_sel;
  logic signed [PW-1:0]   w_ext, x_ext, prod;

  function automatic logic signed [SW-1:0] sext_x(input logic [DW-1:0] v);
    return {{(SW-DW){v[DW-1]}}, v};
  endfunction

  // Add a signed step to a weight, clamping to the representable WW range.
  function automatic logic signed [WW-1:0] sat_add(input logic [WW-1:0] a,
                                                   input logic signed [SW-1:0] d);
    logic signed [SW-1:0] s;
    s = $signed({{(SW-WW){a[WW-1]}}, a}) + d;
    if (s > S_MAX)      return {1'b0, {(WW-1){1'b1}}};
    else if (s < S_MIN) return {1'b1, {(WW-1){1'b0}}};
    else                return s[WW-1:0];
  endfunction

  always_comb begin
    w_sel = '0;
    x_sel = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (idx_q == CW'(i)) begin
        w_sel = w_q[i*WW +: WW];
        x_sel = x_q[i*DW +: DW];
      end
    end
    w_ext = {{DW{w_sel[WW-1]}}, w_sel};
    x_ext = {{WW{x_sel[DW-1]}}, x_sel};
    prod  = w_ext * x_ext;
  end

  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    b_d     = b_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    x_d     = x_q;
    t_d     = t_q;
    last_d  = last_q;
    err_d   = err_q;
    conv_d  = conv_q;
    ecnt_d  = ecnt_q;
`ifdef EPOCH_LIMIT_EN
    lim_d   = lim_q;
`endif
    case (state_q)
      IDLE: if (start) state_d = INIT;
      INIT: begin
        w_d     = '0;
        b_d     = '0;
        acc_d   = '0;
        ecnt_d  = '0;
        err_d   = 1'b0;
        conv_d  = 1'b0;
`ifdef EPOCH_LIMIT_EN
        lim_d   = 1'b0;
`endif
        state_d = REQ;
      end
      REQ: if (sample_valid) begin
        x_d     = sample_x;
        t_d     = sample_t;
        last_d  = sample_last;
        acc_d   = {{(AW-WW){b_q[WW-1]}}, b_q};
        idx_d   = '0;
        state_d = MAC;
      end
      MAC: begin
        acc_d = acc_q + {{(AW-PW){prod[PW-1]}}, prod};
        if (idx_q == LAST_IDX) state_d = DECIDE;
        else                   idx_d   = idx_q + CW'(1);
      end
      DECIDE: begin
        // Sign bit clear means acc >= 0, i.e. the perceptron answers +1.
        if (!acc_q[AW-1] != t_q) begin
          err_d   = 1'b1;
          state_d = UPDATE;
        end else begin
          state_d = last_q ? EPOCH_END : REQ;
        end
      end
      UPDATE: begin
        for (int i = 0; i < N_IN; i++) begin
          w_d[i*WW +: WW] = sat_add(w_q[i*WW +: WW],
                                    t_q ? sext_x(x_q[i*DW +: DW]) : -sext_x(x_q[i*DW +: DW]));
        end
        b_d     = sat_add(b_q, t_q ? S_ONE : -S_ONE);
        state_d = last_q ? EPOCH_END : REQ;
      end
      EPOCH_END: begin
        if (!err_q) begin
          conv_d  = 1'b1;
          state_d = IDLE;
        end else begin
          err_d   = 1'b0;
          if (ecnt_q != 16'hFFFF) ecnt_d = ecnt_q + 16'd1;
          state_d = REQ;
`ifdef EPOCH_LIMIT_EN
          if ((max_epochs != 16'd0) && (ecnt_d == max_epochs)) begin
            lim_d   = 1'b1;
            conv_d  = 1'b0;
            state_d = IDLE;
          end
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      w_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
      x_q     <= '0;
      t_q     <= 1'b0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
      conv_q  <= 1'b0;
      ecnt_q  <= '0;
`ifdef EPOCH_LIMIT_EN
      lim_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      x_q     <= x_d;
      t_q     <= t_d;
      last_q  <= last_d;
      err_q   <= err_d;
      conv_q  <= conv_d;
      ecnt_q  <= ecnt_d;
`ifdef EPOCH_LIMIT_EN
      lim_q   <= lim_d;
`endif
    end
  end

  assign done       = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign sample_req = (state_q == REQ);
  assign converged  = conv_q;
  assign epoch_cnt  = ecnt_q;
  assign w_out      = w_q;
  assign b_out      = b_q;
`ifdef EPOCH_LIMIT_EN
  assign limit_hit  = lim_q;
`endif

endmodule

// File: doc/perceptron_trainer.md
PERCEPTRON_TRAINER -- requirements
Module: perceptron_trainer

Interface
REQ-001 The block SHALL have parameter N_IN, default 2, meaning the number of input features (1..16).
REQ-002 The block SHALL have parameter DW, default 8, meaning the signed feature width.
REQ-003 The block SHALL have parameter WW, default 16, meaning the signed weight and bias width.
REQ-004 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The block SHALL have port start, input, 1 bit: begin training; sampled only in IDLE.
REQ-007 The block SHALL have port sample_req, output, 1 bit: the block is ready to accept a sample.
REQ-008 The block SHALL have port sample_valid, input, 1 bit: a sample is present.
REQ-009 The block SHALL have port sample_x, input, N_IN*DW bits: features, with x[i] at bits [i*DW +: DW], signed.
REQ-010 The block SHALL have port sample_t, input, 1 bit: target, where 1 means +1 and 0 means -1.
REQ-011 The block SHALL have port sample_last, input, 1 bit: the sample is the last one of the epoch.
REQ-012 The block SHALL have port done, output, 1 bit: high in IDLE.
REQ-013 The block SHALL have port busy, output, 1 bit: high in every state other than IDLE.
REQ-014 The block SHALL have port converged, output, 1 bit: the last run ended with an error-free epoch.
REQ-015 The block SHALL have port epoch_cnt, output, 16 bits: the number of completed epochs that contained errors.
REQ-016 The block SHALL have port w_out, output, N_IN*WW bits: current weights, packed the same way as sample_x.
REQ-017 The block SHALL have port b_out, output, WW bits: current bias.

Function
REQ-018 The state machine SHALL have exactly the states IDLE, INIT, REQ, MAC, DECIDE, UPDATE, EPOCH_END.
REQ-019 IDLE SHALL go to INIT when start=1 and otherwise stay in IDLE; converged, epoch_cnt, weights and bias hold their values in IDLE.
REQ-020 INIT SHALL last 1 cycle, zero all weights, bias, epoch_cnt, the accumulator and the epoch error flag, clear converged, and go to REQ.
REQ-021 In REQ, sample_req SHALL be 1; a sample SHALL be accepted only in the cycle where sample_req and sample_valid are both 1, latching x, t and last; after acceptance the state goes to MAC.
REQ-022 sample_req SHALL be 0 in every state except REQ; sample_valid outside REQ SHALL be ignored.
REQ-023 MAC SHALL last exactly N_IN cycles: the accumulator is preloaded with b, and cycle i adds w[i]*x[i].
REQ-024 The accumulator SHALL be signed, WW+DW+clog2(N_IN)+1 bits wide, and SHALL never overflow.
REQ-025 DECIDE SHALL last 1 cycle and compute y=+1 if acc>=0, else y=-1.
REQ-026 If y!=t, DECIDE SHALL go to UPDATE and set the epoch error flag.
REQ-027 If y==t, DECIDE SHALL go to EPOCH_END when last=1, else to REQ.
REQ-028 UPDATE SHALL last 1 cycle and perform all updates in parallel: w[i]+=x[i] and b+=1 when t=+1; w[i]-=x[i] and b-=1 when t=-1.
REQ-029 Each weight and bias update SHALL saturate to the signed WW range [-2^(WW-1), 2^(WW-1)-1].
REQ-030 UPDATE SHALL go to EPOCH_END when last=1, else to REQ.
REQ-031 EPOCH_END, with the error flag clear, SHALL set converged=1 and go to IDLE.
REQ-032 EPOCH_END, with the error flag set, SHALL increment epoch_cnt, clear the flag, and go to REQ.
REQ-033 epoch_cnt SHALL saturate at 16'hFFFF and SHALL NOT wrap.
REQ-034 Per-sample latency from acceptance SHALL be N_IN+1 cycles without an update and N_IN+2 cycles with an update, plus 1 cycle for EPOCH_END.
REQ-035 start SHALL be ignored while busy=1.

Reset
REQ-036 When rst=0, the block SHALL enter IDLE immediately, including when reset is asserted mid-operation.
REQ-037 During reset, done SHALL be 1; busy, sample_req and converged SHALL be 0; epoch_cnt, w_out, b_out and the accumulator SHALL be 0.
REQ-038 On rst release, the first state transition SHALL occur on the next rising clk edge.

Configuration
REQ-039 With EPOCH_LIMIT_EN defined, the block SHALL add input max_epochs (16 bits) and output limit_hit (1 bit).
REQ-040 With EPOCH_LIMIT_EN defined, when EPOCH_END increments epoch_cnt to a value equal to max_epochs, the block SHALL go to IDLE with converged=0 and limit_hit=1.
REQ-041 With EPOCH_LIMIT_EN defined, max_epochs=0 SHALL mean no limit, and limit_hit SHALL be cleared in INIT and during reset.
REQ-042 Without EPOCH_LIMIT_EN, the ports max_epochs and limit_hit SHALL be absent and training SHALL run until convergence.

Verification (N_IN=2, DW=8, WW=16)
REQ-043 Reset: hold rst=0 mid-MAC -> done=1, busy=0, sample_req=0, w_out=0, b_out=0, epoch_cnt=0 in the same cycle.
REQ-044 Correct first guess: start, then sample x=(3,-2), t=+1, last=1 -> no UPDATE; converged=1, epoch_cnt=0; done rises 4 cycles after acceptance.
REQ-045 Update then convergence: sample x=(3,-2), t=-1, last=1 -> w=(-3,2), b=-1, epoch_cnt=1; the same sample again gives acc=-14 -> converged=1, epoch_cnt=1.
REQ-046 Stall: hold sample_valid=0 for 10 cycles in REQ -> sample_req stays 1, state and weights unchanged; acceptance occurs on the first cycle with valid=1.
REQ-047 Saturation: WW=8, sample x=(127,0), t=+1 forced to mismatch by a preceding t=-1 sample -> w[0] clamps at 127 / -128 and never wraps.
REQ-048 Epoch limit (EPOCH_LIMIT_EN defined): XOR dataset of 4 samples, max_epochs=5 -> done with converged=0, limit_hit=1, epoch_cnt=5.
